logic_pair_pipe: RTL and testbench

//  Parametrised, pipelined successor of the two-input AND/OR gate pair. Operates on WIDTH-bit operands.

---
 rtl/logic_pair_pkg.sv | 43 ++++
 rtl/logic_pair_stage.sv | 45 ++++
 rtl/logic_pair_pipe.sv | 163 ++++++++++++++++
 tb/tb_logic_pair_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pair_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pair_pkg
//  Description : Shared types and helpers for the logic_pair_pipe datapath.
//                Defines the operator-pair encoding, the per-bit operator
//                evaluation function and the supported pipeline depth limit.
//  Revision    : 1.0  initial release
// ============================================================================
package logic_pair_pkg;

    // Deepest pipeline the top accepts for its STAGES parameter.
    localparam int MAX_STAGES = 4;

    // Operator pair selected per transaction; the value travels on op_sel.
    typedef enum logic [1:0] {
        OP_AND_OR   = 2'd0,   // {a&b,    a|b}
        OP_NAND_NOR = 2'd1,   // {~(a&b), ~(a|b)}
        OP_XOR_XNOR = 2'd2,   // {a^b,    ~(a^b)}
        OP_HALF_ADD = 2'd3    // {a&b,    a^b}  carry / sum
    } op_pair_e;

    // Evaluates one bit position of the selected operator pair.
    // Returns {y, z}. Operands are bitwise, so the top applies this per bit,
    // which keeps the function independent of WIDTH.
    function automatic logic [1:0] logic_pair_eval(
        input logic     a,
        input logic     b,
        input op_pair_e op
    );
        logic [1:0] r;
        r = 2'b00;
        case (op)
            OP_AND_OR:   r = {a & b,    a | b};
            OP_NAND_NOR: r = {~(a & b), ~(a | b)};
            OP_XOR_XNOR: r = {a ^ b,    ~(a ^ b)};
            OP_HALF_ADD: r = {a & b,    a ^ b};
            default:     r = 2'b00;
        endcase
        return r;
    endfunction

endpackage : logic_pair_pkg
`default_nettype wire

// File: rtl/logic_pair_stage.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pair_stage
//  Description : One valid/data register slot of the logic_pair_pipe pipeline.
//                The slot loads whenever it is empty or its current contents
//                leave in the same cycle; otherwise valid and data hold.
//  Ports       : clk, rst       clock, asynchronous active-high reset
//                up_valid       a beat is offered by the previous slot/input
//                up_data        payload of the offered beat
//                adv_ok         downstream can take this slot's beat now
//                valid, data    registered slot contents
//  Revision    : 1.0  initial release
// ============================================================================
module logic_pair_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic              adv_ok,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // The slot is free to load when empty or when its beat moves on this cycle.
    logic load_ok;
    assign load_ok = !valid || adv_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load_ok) begin
            valid <= up_valid;
            // Data only changes when a real beat arrives; a bubble leaves the
            // old payload in place, harmlessly masked by valid=0.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule : logic_pair_stage
`default_nettype wire

// File: rtl/logic_pair_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pair_pipe
//  Description : Pipelined, parametrised AND/OR-style gate pair. For each
//                accepted operand beat the selected operator pair {y,z} is
//                evaluated at acceptance and carried through STAGES register
//                slots with valid/ready flow control on both sides. A
//                saturating counter reports delivered results.
//  Parameters  : WIDTH   operand/result width (>=1)
//                STAGES  register stages, 1..MAX_STAGES
//                CNT_W   transaction counter width
//  Ports       : clk, rst               clock, asynchronous active-high reset
//                in_valid, in_ready     operand-side handshake
//                a, b, op_sel           operands and operator pair select
//                out_valid, out_ready   result-side handshake
//                y, z                   result pair
//                op_count               results delivered, saturating
//                y_any, z_all           (LOGIC_PAIR_REDUCE_EN only) |y and &z
//  Config      : define LOGIC_PAIR_REDUCE_EN to add the y_any/z_all outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module logic_pair_pipe
    import logic_pair_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_PAIR_REDUCE_EN
    ,
    output logic             y_any,
    output logic             z_all
`endif
);

`ifdef LOGIC_PAIR_REDUCE_EN
    localparam int RED_W = 2;
`else
    localparam int RED_W = 0;
`endif
    // Payload layout, MSB first: {reduce bits (optional), y, z}
    localparam int PAY_W = 2 * WIDTH + RED_W;

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("logic_pair_pipe: STAGES must be in 1..%0d", MAX_STAGES);
    end

    // ------------------------------------------------------------------------
    // Result evaluation at acceptance
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] z_in;
    logic [PAY_W-1:0] payload;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [1:0] yz;
        assign yz      = logic_pair_eval(a[i], b[i], op_pair_e'(op_sel));
        assign y_in[i] = yz[1];
        assign z_in[i] = yz[0];
    end

`ifdef LOGIC_PAIR_REDUCE_EN
    // Reductions are taken on the fresh results so they ride in the same
    // slots as y/z and stay aligned with out_valid.
    assign payload = {|y_in, &z_in, y_in, z_in};
`else
    assign payload = {y_in, z_in};
`endif

    // ------------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------------
    logic [STAGES-1:0]            stg_valid;
    logic [STAGES-1:0][PAY_W-1:0] stg_data;
    logic [STAGES-1:0]            down_ok;

    // down_ok[k]: the slot after stage k (or the consumer) can take a beat
    // this cycle. A beat in stage k can move whenever any later slot is empty,
    // because everything between it and that hole shifts forward together.
    // Built directly from the slot valids so no ready bit depends on another.
    always_comb begin
        down_ok = '0;
        for (int k = 0; k < STAGES; k++) begin
            down_ok[k] = out_ready;
            for (int j = k + 1; j < STAGES; j++) begin
                if (!stg_valid[j]) begin
                    down_ok[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = !stg_valid[0] || down_ok[0];

    // ------------------------------------------------------------------------
    // Register slots
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            logic_pair_stage #(
                .DATA_W (PAY_W)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .up_valid (in_valid),
                .up_data  (payload),
                .adv_ok   (down_ok[k]),
                .valid    (stg_valid[k]),
                .data     (stg_data[k])
            );
        end else begin : g_rest
            logic_pair_stage #(
                .DATA_W (PAY_W)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .up_valid (stg_valid[k-1]),
                .up_data  (stg_data[k-1]),
                .adv_ok   (down_ok[k]),
                .valid    (stg_valid[k]),
                .data     (stg_data[k])
            );
        end
    end

    // ------------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------------
    logic out_xfer;

    assign out_valid = stg_valid[STAGES-1];
    assign out_xfer  = out_valid && out_ready;
    assign y         = stg_data[STAGES-1][2*WIDTH-1:WIDTH];
    assign z         = stg_data[STAGES-1][WIDTH-1:0];

`ifdef LOGIC_PAIR_REDUCE_EN
    assign y_any     = stg_data[STAGES-1][PAY_W-1];
    assign z_all     = stg_data[STAGES-1][PAY_W-2];
`endif

    // Saturating count of delivered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_xfer && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule : logic_pair_pipe
`default_nettype wire

// File: tb/tb_logic_pair_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_pair_pipe
//  Description : Self-checking bench for logic_pair_pipe. Three instances:
//                main (WIDTH=8, STAGES=2), counter (CNT_W=3) and a 1-bit
//                single-stage copy. Directed tables plus random traffic
//                checked against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_logic_pair_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- main instance ----------------
    logic         m_in_valid = 0, m_in_ready, m_out_valid, m_out_ready = 0;
    logic [W-1:0] m_a = 0, m_b = 0, m_y, m_z;
    logic [1:0]   m_op = 0;
    logic [15:0]  m_cnt;
`ifdef LOGIC_PAIR_REDUCE_EN
    logic m_y_any, m_z_all;
`endif

    logic_pair_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .op_sel(m_op), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .y(m_y), .z(m_z), .op_count(m_cnt)
`ifdef LOGIC_PAIR_REDUCE_EN
        , .y_any(m_y_any), .z_all(m_z_all)
`endif
    );

    // ---------------- counter instance (CNT_W=3) ----------------
    logic         c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [W-1:0] c_a = 0, c_b = 0, c_y, c_z;
    logic [1:0]   c_op = 0;
    logic [2:0]   c_cnt;
`ifdef LOGIC_PAIR_REDUCE_EN
    logic c_y_any, c_z_all;
`endif

    logic_pair_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(3)) dut_cnt (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .a(c_a), .b(c_b), .op_sel(c_op), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .y(c_y), .z(c_z), .op_count(c_cnt)
`ifdef LOGIC_PAIR_REDUCE_EN
        , .y_any(c_y_any), .z_all(c_z_all)
`endif
    );

    // ---------------- 1-bit, single-stage instance ----------------
    logic        w_in_valid = 0, w_in_ready, w_out_valid, w_out_ready = 0;
    logic [0:0]  w_a = 0, w_b = 0, w_y, w_z;
    logic [1:0]  w_op = 0;
    logic [15:0] w_cnt;
`ifdef LOGIC_PAIR_REDUCE_EN
    logic w_y_any, w_z_all;
`endif

    logic_pair_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(16)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .op_sel(w_op), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .y(w_y), .z(w_z), .op_count(w_cnt)
`ifdef LOGIC_PAIR_REDUCE_EN
        , .y_any(w_y_any), .z_all(w_z_all)
`endif
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] y;
        logic [W-1:0] z;
    } res_t;

    // Reference: the operator-pair table written over whole words.
    function automatic res_t ref_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [1:0] op);
        res_t r;
        case (op)
            2'd0:    begin r.y = a & b;    r.z = a | b;    end
            2'd1:    begin r.y = ~(a & b); r.z = ~(a | b); end
            2'd2:    begin r.y = a ^ b;    r.z = ~(a ^ b); end
            default: begin r.y = a & b;    r.z = a ^ b;    end
        endcase
        return r;
    endfunction

    res_t         exp_q[$];
    int           exp_count = 0;
    logic         hold_prev = 1'b0;
    logic [W-1:0] prev_y, prev_z;

    // One clock of the main instance: drive, check against the model, update.
    task automatic m_cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic ordy,
                           output logic ir, output logic ov);
        res_t f;
        @(negedge clk);
        m_in_valid = iv; m_a = a; m_b = b; m_op = op; m_out_ready = ordy;
        #1;
        ir = m_in_ready;
        ov = m_out_valid;
        chk("in_ready", {31'd0, ir}, {31'd0, (exp_q.size() < S) || ordy});
        chk("op_count", {16'd0, m_cnt}, exp_count);
        if (hold_prev) begin
            chk("hold_valid", {31'd0, ov}, 32'd1);
            chk("hold_y", {24'd0, m_y}, {24'd0, prev_y});
            chk("hold_z", {24'd0, m_z}, {24'd0, prev_z});
        end
        if (ov) begin
            chk("beat_present", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                f = exp_q[0];
                chk("y", {24'd0, m_y}, {24'd0, f.y});
                chk("z", {24'd0, m_z}, {24'd0, f.z});
`ifdef LOGIC_PAIR_REDUCE_EN
                chk("y_any", {31'd0, m_y_any}, {31'd0, |f.y});
                chk("z_all", {31'd0, m_z_all}, {31'd0, &f.z});
`endif
                if (ordy) begin
                    void'(exp_q.pop_front());
                    exp_count++;
                end
            end
        end
        hold_prev = ov && !ordy;
        prev_y    = m_y;
        prev_z    = m_z;
        if (iv && ir) exp_q.push_back(ref_eval(a, b, op));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_in_valid = 0; c_in_valid = 0; w_in_valid = 0;
        #1;
        chk("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
        chk("rst_y", {24'd0, m_y}, 32'd0);
        chk("rst_z", {24'd0, m_z}, 32'd0);
        chk("rst_count", {16'd0, m_cnt}, 32'd0);
        chk("rst_cnt3", {29'd0, c_cnt}, 32'd0);
        chk("rst_w1_valid", {31'd0, w_out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, m_in_ready}, 32'd1);
        chk("rst_w1_in_ready", {31'd0, w_in_ready}, 32'd1);
        exp_q.delete();
        exp_count = 0;
        hold_prev = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] y;
        logic [W-1:0] z;
    } vec_t;

    vec_t t2[4];
    vec_t t3[4];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin : main_test
        logic ir, ov;
        int   beat, acc, xf, guard;

        t2[0] = '{8'hF0, 8'hCC, 2'd0, 8'hC0, 8'hFC};
        t2[1] = '{8'hF0, 8'hCC, 2'd1, 8'h3F, 8'h03};
        t2[2] = '{8'hF0, 8'hCC, 2'd2, 8'h3C, 8'hC3};
        t2[3] = '{8'hF0, 8'hCC, 2'd3, 8'hC0, 8'h3C};
        t3[0] = '{8'd0, 8'd0, 2'd0, 8'd0, 8'd0};
        t3[1] = '{8'd0, 8'd1, 2'd0, 8'd0, 8'd1};
        t3[2] = '{8'd1, 8'd0, 2'd0, 8'd0, 8'd1};
        t3[3] = '{8'd1, 8'd1, 2'd0, 8'd1, 8'd1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Operator table, back-to-back, latency 2.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) m_cycle(1'b1, t2[c].a, t2[c].b, t2[c].op, 1'b1, ir, ov);
            else       m_cycle(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, ir, ov);
            chk("t2_out_valid", {31'd0, ov}, {31'd0, c >= 2});
            if (c >= 2) begin
                chk("t2_y", {24'd0, m_y}, {24'd0, t2[c-2].y});
                chk("t2_z", {24'd0, m_z}, {24'd0, t2[c-2].z});
            end
        end

        // Reset with two beats in flight; nothing stale afterwards.
        m_cycle(1'b1, 8'h12, 8'h34, 2'd2, 1'b0, ir, ov);
        m_cycle(1'b1, 8'h56, 8'h78, 2'd3, 1'b0, ir, ov);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            m_cycle(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, ir, ov);
            chk("no_stale", {31'd0, ov}, 32'd0);
        end

        // Backpressure for 5 cycles while streaming.
        beat = 0;
        for (int c = 0; c < 5; c++) begin
            m_cycle(1'b1, 8'h10 + beat[7:0], 8'h0F, beat[1:0], 1'b0, ir, ov);
            chk("t4_in_ready", {31'd0, ir}, {31'd0, c < 2});
            if (ir) beat++;
        end
        guard = 0;
        while ((exp_q.size() != 0 || m_out_valid) && guard < 10) begin
            m_cycle(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, ir, ov);
            guard++;
        end
        chk("t4_drained", exp_q.size(), 32'd0);
        chk("t4_delivered", exp_count, 32'd2);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            m_cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, ir, ov);
        end
        guard = 0;
        while ((exp_q.size() != 0 || m_out_valid) && guard < 20) begin
            m_cycle(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, ir, ov);
            guard++;
        end
        chk("rand_drained", exp_q.size(), 32'd0);

`ifdef LOGIC_PAIR_REDUCE_EN
        // Reduction outputs.
        for (int c = 0; c < 4; c++) begin
            m_cycle(c < 2, 8'h00, 8'h00, (c == 0) ? 2'd1 : 2'd0, 1'b1, ir, ov);
            if (c == 2) begin
                chk("red_y", {24'd0, m_y}, 32'hFF);
                chk("red_z", {24'd0, m_z}, 32'hFF);
                chk("red_y_any1", {31'd0, m_y_any}, 32'd1);
                chk("red_z_all1", {31'd0, m_z_all}, 32'd1);
            end
            if (c == 3) begin
                chk("red_y_any0", {31'd0, m_y_any}, 32'd0);
                chk("red_z_all0", {31'd0, m_z_all}, 32'd0);
            end
        end
`endif

        // 1-bit sweep on the single-stage copy, latency 1.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            w_in_valid  = (c < 4);
            w_a         = (c < 4) ? t3[c].a[0:0] : 1'b0;
            w_b         = (c < 4) ? t3[c].b[0:0] : 1'b0;
            w_op        = 2'd0;
            w_out_ready = 1'b1;
            #1;
            chk("w1_in_ready", {31'd0, w_in_ready}, 32'd1);
            chk("w1_out_valid", {31'd0, w_out_valid}, {31'd0, c >= 1});
            if (c >= 1) begin
                chk("w1_y", {31'd0, w_y}, {31'd0, t3[c-1].y[0]});
                chk("w1_z", {31'd0, w_z}, {31'd0, t3[c-1].z[0]});
            end
        end

        // Saturating 3-bit counter over 9 deliveries.
        acc = 0; xf = 0; guard = 0;
        while ((xf < 9) && guard < 30) begin
            @(negedge clk);
            c_in_valid  = (acc < 9);
            c_a         = 8'(acc);
            c_b         = 8'hA5;
            c_op        = 2'(acc);
            c_out_ready = 1'b1;
            #1;
            chk("cnt3", {29'd0, c_cnt}, (xf > 7) ? 32'd7 : xf);
            if (c_in_valid && c_in_ready) acc++;
            if (c_out_valid) xf++;
            guard++;
        end
        @(negedge clk);
        c_in_valid = 1'b0;
        #1;
        chk("cnt3_delivered", xf, 32'd9);
        chk("cnt3_sat", {29'd0, c_cnt}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_logic_pair_pipe
`default_nettype wire
